// File: rtl/aoi_chk_pkg.sv
// Shared types and helpers for the AOI response checker: FSM state encoding,
// error counter width and the reference AOI response function.
package aoi_chk_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } aoi_state_t;

  // vec = {a,b,c,d}; result = {e,f,g} with e = a&b, f = c&d, g = ~(e|f)
  function automatic logic [2:0] aoi_expected(input logic [3:0] vec);
    logic e_x;
    logic f_x;
    e_x = vec[3] & vec[2];
    f_x = vec[1] & vec[0];
    return {e_x, f_x, ~(e_x | f_x)};
  endfunction

endpackage

// File: rtl/aoi_expect.sv
// Combinational expected-response model for one AOI stimulus vector.
module aoi_expect
  import aoi_chk_pkg::*;
(
  input  logic [3:0] vec,
  output logic [2:0] exp_resp
);

  assign exp_resp = aoi_expected(vec);

endmodule

// File: rtl/aoi_response_checker.sv
// Sweeps all 16 {a,b,c,d} vectors into an AOI gate and counts wrong {e,f,g}.
// Optional first-failure capture is enabled by defining AOI_CHK_FIRST_FAIL_EN.
module aoi_response_checker
  import aoi_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef AOI_CHK_FIRST_FAIL_EN
  output logic             fail_valid,
  output logic [3:0]       fail_vec,
`endif
  output aoi_state_t       state_dbg
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST   = 4'(PASSES - 1);

  aoi_state_t state;
  aoi_state_t state_nxt;
  logic [3:0] vec;
  logic [3:0] pass_cnt;
  logic [3:0] settle_cnt;
  logic [2:0] resp_q;
  logic [2:0] exp_resp;
  logic       mismatch;

  aoi_expect u_expect (
    .vec      (vec),
    .exp_resp (exp_resp)
  );

  assign busy      = (state == DRIVE) || (state == SETTLE) ||
                     (state == SAMPLE) || (state == NEXT);
  assign done      = (state == DONE);
  assign {a, b, c, d} = busy ? vec : 4'd0;
  assign mismatch  = (state == SAMPLE) && (resp_q != exp_resp);
  assign state_dbg = state;

  // DRIVE already counts as the first held cycle, so a single settle cycle
  // skips the SETTLE state entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = DRIVE;
      DRIVE:  state_nxt = (SETTLE_CYCLES > 1) ? SETTLE : SAMPLE;
      SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE: state_nxt = NEXT;
      NEXT:   state_nxt = (vec == 4'hF && pass_cnt == PASS_LAST) ? DONE : DRIVE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= 4'd0;
      pass_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      resp_q     <= 3'd0;
      err_count  <= '0;
      pass       <= 1'b0;
`ifdef AOI_CHK_FIRST_FAIL_EN
      fail_valid <= 1'b0;
      fail_vec   <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      // The response is captured on the edge that ends the settle window.
      if (state_nxt == SAMPLE) resp_q <= {e, f, g};
      case (state)
        IDLE: if (start) begin
          vec       <= 4'd0;
          pass_cnt  <= 4'd0;
          err_count <= '0;
          pass      <= 1'b0;
`ifdef AOI_CHK_FIRST_FAIL_EN
          fail_valid <= 1'b0;
          fail_vec   <= 4'd0;
`endif
        end
        DRIVE:  settle_cnt <= 4'd1;
        SETTLE: settle_cnt <= settle_cnt + 4'd1;
        SAMPLE: if (mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
`ifdef AOI_CHK_FIRST_FAIL_EN
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= vec;
          end
`endif
        end
        NEXT: begin
          vec <= vec + 4'd1;
          if (vec == 4'hF) pass_cnt <= pass_cnt + 4'd1;
          if (state_nxt == DONE) pass <= (err_count == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi_response_checker.sv
// Directed bench for aoi_response_checker: three instances (defaults,
// PASSES=3, SETTLE_CYCLES=1) each driving a bench-side AOI gate with fault modes.
module tb_aoi_response_checker;
  import aoi_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // gate modes: 0 good, 1 g stuck 0, 2 e stuck 1, 3 good but one cycle late
  int mode0 = 0;
  int mode3 = 0;
  int mode1 = 0;

  function automatic logic [2:0] gate_resp(input int mode, input logic [3:0] v,
                                           input logic [2:0] dly);
    logic ee;
    logic ff;
    ee = v[3] & v[2];
    ff = v[1] & v[0];
    case (mode)
      1:       return {ee, ff, 1'b0};
      2:       return {1'b1, ff, ~(ee | ff)};
      3:       return dly;
      default: return {ee, ff, ~(ee | ff)};
    endcase
  endfunction

  function automatic logic [2:0] good_resp(input logic [3:0] v);
    return {v[3] & v[2], v[1] & v[0], ~((v[3] & v[2]) | (v[1] & v[0]))};
  endfunction

  // ---------------- instance 0: defaults ----------------
  logic start0 = 1'b0;
  logic a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0;
  logic [7:0] err0;
  logic [2:0] dly0;
  aoi_state_t st0;
  logic fv0_valid;
  logic [3:0] fv0_vec;
  assign {e0, f0, g0} = gate_resp(mode0, {a0, b0, c0, d0}, dly0);
  always_ff @(posedge clk) dly0 <= good_resp({a0, b0, c0, d0});

  aoi_response_checker u_dut (
    .clk(clk), .rst(rst), .start(start0),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
`ifdef AOI_CHK_FIRST_FAIL_EN
    .fail_valid(fv0_valid), .fail_vec(fv0_vec),
`endif
    .state_dbg(st0)
  );
`ifndef AOI_CHK_FIRST_FAIL_EN
  assign fv0_valid = 1'b0;
  assign fv0_vec   = 4'd0;
`endif

  // ---------------- instance 3: PASSES=3 ----------------
  logic start3 = 1'b0;
  logic a3, b3, c3, d3, e3, f3, g3, busy3, done3, pass3;
  logic [7:0] err3;
  logic [2:0] dly3;
  aoi_state_t st3;
  assign {e3, f3, g3} = gate_resp(mode3, {a3, b3, c3, d3}, dly3);
  always_ff @(posedge clk) dly3 <= good_resp({a3, b3, c3, d3});
`ifdef AOI_CHK_FIRST_FAIL_EN
  logic fv3_valid;
  logic [3:0] fv3_vec;
`endif

  aoi_response_checker #(.SETTLE_CYCLES(2), .PASSES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .f(f3), .g(g3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
`ifdef AOI_CHK_FIRST_FAIL_EN
    .fail_valid(fv3_valid), .fail_vec(fv3_vec),
`endif
    .state_dbg(st3)
  );

  // ---------------- instance 1: SETTLE_CYCLES=1 ----------------
  logic start1 = 1'b0;
  logic a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
  logic [7:0] err1;
  logic [2:0] dly1;
  aoi_state_t st1;
  assign {e1, f1, g1} = gate_resp(mode1, {a1, b1, c1, d1}, dly1);
  always_ff @(posedge clk) dly1 <= good_resp({a1, b1, c1, d1});
`ifdef AOI_CHK_FIRST_FAIL_EN
  logic fv1_valid;
  logic [3:0] fv1_vec;
`endif

  aoi_response_checker #(.SETTLE_CYCLES(1), .PASSES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
`ifdef AOI_CHK_FIRST_FAIL_EN
    .fail_valid(fv1_valid), .fail_vec(fv1_vec),
`endif
    .state_dbg(st1)
  );

  // ---------------- standalone expected-value model ----------------
  logic [3:0] exp_vec = 4'd0;
  logic [2:0] exp_out;
  aoi_expect u_exp (.vec(exp_vec), .exp_resp(exp_out));

  // ---------------- driver helpers ----------------
  task automatic set_start(input int which, input logic val);
    case (which)
      3:       start3 = val;
      1:       start1 = val;
      default: start0 = val;
    endcase
  endtask

  function automatic logic done_of(input int which);
    case (which)
      3:       return done3;
      1:       return done1;
      default: return done0;
    endcase
  endfunction

  // Pulses start for one cycle and returns edges from the accepting edge to done.
  task automatic run_and_wait(input int which, input int limit, output int cyc);
    @(posedge clk); #1;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    set_start(which, 1'b0);
    cyc = 0;
    while (!done_of(which) && cyc < limit) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (st0 !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", st0, IDLE); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", busy0, done0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", pass0); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err0); end
    checks++; if ({a0, b0, c0, d0} !== 4'd0) begin errors++; $display("FAIL reset_abcd got=%b exp=0000", {a0, b0, c0, d0}); end
    rst = 1'b0;
  endtask

  task automatic test_expect_model();
    logic [2:0] tab [16];
    tab = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b001, 3'b010,
            3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b110};
    for (int i = 0; i < 16; i++) begin
      exp_vec = 4'(i);
      #1;
      checks++;
      if (exp_out !== tab[i]) begin
        errors++;
        $display("FAIL expect_model vec=%0d got=%b exp=%b", i, exp_out, tab[i]);
      end
    end
  endtask

  task automatic test_good_sweep();
    int cyc;
    int n_drive;
    logic order_bad;
    logic stable_bad;
    logic [3:0] held;
    mode0 = 0;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    checks++; if (busy0 !== 1'b1 || st0 !== DRIVE) begin errors++; $display("FAIL sweep_first_busy got busy=%b st=%0d exp busy=1 st=%0d", busy0, st0, DRIVE); end
    cyc = 0; n_drive = 0; order_bad = 1'b0; stable_bad = 1'b0; held = 4'd0;
    while (!done0 && cyc < 400) begin
      if (st0 == DRIVE) begin
        held = {a0, b0, c0, d0};
        if (held !== 4'(n_drive)) order_bad = 1'b1;
        n_drive++;
      end else if ((st0 == SETTLE || st0 == SAMPLE) && {a0, b0, c0, d0} !== held) begin
        stable_bad = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 64) begin errors++; $display("FAIL sweep_latency got=%0d exp=64", cyc); end
    checks++; if (n_drive !== 16 || order_bad) begin errors++; $display("FAIL sweep_order got drives=%0d bad=%b exp drives=16 bad=0", n_drive, order_bad); end
    checks++; if (stable_bad) begin errors++; $display("FAIL sweep_stable got=1 exp=0"); end
    checks++; if (pass0 !== 1'b1 || err0 !== 8'd0) begin errors++; $display("FAIL sweep_result got pass=%b err=%0d exp pass=1 err=0", pass0, err0); end
    checks++; if ({a0, b0, c0, d0} !== 4'd0 || busy0 !== 1'b0) begin errors++; $display("FAIL sweep_done_idle_outs got abcd=%b busy=%b exp 0000 0", {a0, b0, c0, d0}, busy0); end
    @(posedge clk); #1;
    checks++; if (done0 !== 1'b0 || st0 !== IDLE) begin errors++; $display("FAIL sweep_done_pulse got done=%b st=%0d exp done=0 st=%0d", done0, st0, IDLE); end
    checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL sweep_pass_held got=%b exp=1", pass0); end
  endtask

  task automatic test_start_held();
    int cyc;
    logic gap;
    mode0 = 0;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    cyc = 0; gap = 1'b0;
    while (!done0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (!done0 && !busy0) gap = 1'b1;
    end
    checks++; if (cyc !== 64 || gap) begin errors++; $display("FAIL held_single_run got cyc=%0d gap=%b exp cyc=64 gap=0", cyc, gap); end
    @(posedge clk); #1;
    checks++; if (st0 !== IDLE || {a0, b0, c0, d0} !== 4'd0) begin errors++; $display("FAIL held_done_ignores got st=%0d abcd=%b exp st=%0d abcd=0000", st0, {a0, b0, c0, d0}, IDLE); end
    @(posedge clk); #1;
    checks++; if (st0 !== DRIVE) begin errors++; $display("FAIL held_restart_from_idle got=%0d exp=%0d", st0, DRIVE); end
    start0 = 1'b0;
    cyc = 0;
    while (!done0 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cyc !== 64 || pass0 !== 1'b1) begin errors++; $display("FAIL held_second_run got cyc=%0d pass=%b exp cyc=64 pass=1", cyc, pass0); end
  endtask

  task automatic test_g_stuck0();
    int cyc;
    mode0 = 1;
    run_and_wait(0, 400, cyc);
    checks++; if (cyc !== 64) begin errors++; $display("FAIL gstuck_latency got=%0d exp=64", cyc); end
    checks++; if (err0 !== 8'd9) begin errors++; $display("FAIL gstuck_err got=%0d exp=9", err0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL gstuck_pass got=%b exp=0", pass0); end
`ifdef AOI_CHK_FIRST_FAIL_EN
    checks++; if (fv0_valid !== 1'b1 || fv0_vec !== 4'd0) begin errors++; $display("FAIL gstuck_first_fail got v=%b vec=%b exp v=1 vec=0000", fv0_valid, fv0_vec); end
`endif
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic spurious;
    mode0 = 1;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    // vectors 0..4 sampled by now; 0,1,2,4 expect g=1
    checks++; if (err0 !== 8'd4 || busy0 !== 1'b1) begin errors++; $display("FAIL midrst_before got err=%0d busy=%b exp err=4 busy=1", err0, busy0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy0 !== 1'b0 || err0 !== 8'd0 || st0 !== IDLE) begin errors++; $display("FAIL midrst_after got busy=%b err=%0d st=%0d exp busy=0 err=0 st=%0d", busy0, err0, st0, IDLE); end
    checks++; if ({a0, b0, c0, d0} !== 4'd0 || fv0_valid !== 1'b0) begin errors++; $display("FAIL midrst_outs got abcd=%b fv=%b exp 0000 0", {a0, b0, c0, d0}, fv0_valid); end
    spurious = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done0 || busy0) spurious = 1'b1;
    end
    checks++; if (spurious) begin errors++; $display("FAIL midrst_no_done got=1 exp=0"); end
    mode0 = 0;
    run_and_wait(0, 400, cyc);
    checks++; if (cyc !== 64 || pass0 !== 1'b1 || err0 !== 8'd0) begin errors++; $display("FAIL midrst_clean_run got cyc=%0d pass=%b err=%0d exp 64 1 0", cyc, pass0, err0); end
  endtask

  task automatic test_e_stuck1_passes3();
    int cyc;
    mode3 = 2;
    run_and_wait(3, 600, cyc);
    checks++; if (cyc !== 192) begin errors++; $display("FAIL estuck_latency got=%0d exp=192", cyc); end
    checks++; if (err3 !== 8'd36 || pass3 !== 1'b0) begin errors++; $display("FAIL estuck_err got err=%0d pass=%b exp err=36 pass=0", err3, pass3); end
  endtask

  task automatic test_settle_delayed_gate();
    int cyc;
    mode1 = 3;
    run_and_wait(1, 400, cyc);
    checks++; if (cyc !== 48) begin errors++; $display("FAIL settle1_latency got=%0d exp=48", cyc); end
    // each vector sees the previous vector's response: 3,4,7,8,11,12,15 differ
    checks++; if (err1 !== 8'd7 || pass1 !== 1'b0) begin errors++; $display("FAIL settle1_err got err=%0d pass=%b exp err=7 pass=0", err1, pass1); end
    mode0 = 3;
    run_and_wait(0, 400, cyc);
    checks++; if (cyc !== 64 || err0 !== 8'd0 || pass0 !== 1'b1) begin errors++; $display("FAIL settle2_delayed got cyc=%0d err=%0d pass=%b exp 64 0 1", cyc, err0, pass0); end
  endtask

  initial begin
    test_reset();
    test_expect_model();
    test_good_sweep();
    test_start_held();
    test_g_stuck0();
    test_reset_mid_run();
    test_e_stuck1_passes3();
    test_settle_delayed_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
